// File: rtl/uart_tx_queue_pkg.sv
// Shared types and constants for the UART transmit queue.
// Holds the byte width and the handshake FSM state encoding.
package uart_tx_queue_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2,
    S_GAP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with wrapping head/tail pointers and an occupancy count that can represent DEPTH.
// A flush may optionally keep the head entry, which is the byte currently on the serial line.
module uart_byte_fifo
  import uart_tx_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] push_data,
  input  logic                   pop,
  input  logic                   flush,
  input  logic                   keep_head,
  output logic [UART_DATA_W-1:0] head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]          head_q, head_d;
  logic [AW-1:0]          tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   wr_ok;

  assign wr_ok = push && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d  = head_q + AW'(1);
      count_d = count_q - CW'(1);
    end
    // A kept head that is popped on the same edge leaves nothing behind.
    if (flush) begin
      if (keep_head && !pop) begin
        tail_d  = head_q + AW'(1);
        count_d = CW'(1);
      end else begin
        tail_d  = head_d;
        count_d = '0;
      end
    end else if (push) begin
      tail_d  = tail_q + AW'(1);
      count_d = count_d + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[tail_q] <= push_data;
    end
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding uart_transmitter: buffers bytes and hands them over one frame at a time
// using a send/busy handshake, with an optional idle gap between frames.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   flush,
  input  logic                   clear_overflow,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic                   tx_send,
  input  logic                   tx_busy
);

  localparam int unsigned GapW = $clog2(GAP_CYCLES + 2);

  tx_state_e              state_q, state_d;
  logic                   busy_q;
  logic                   tx_send_q, tx_send_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic [GapW-1:0]        gap_q, gap_d;
  logic                   overflow_q, overflow_d;
  logic [UART_DATA_W-1:0] head_data;
  logic                   pop, push_ok, keep_head;

  // The head byte is only released once its frame has fully completed.
  assign pop       = (state_q == S_BUSY) && !busy_q;
  assign keep_head = (state_q == S_REQ) || (state_q == S_BUSY);
  assign push_ok   = wr_en && !flush && (!full || pop);

  uart_byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_ok),
    .push_data(wr_data),
    .pop      (pop),
    .flush    (flush),
    .keep_head(keep_head),
    .head_data(head_data),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    state_d   = state_q;
    tx_send_d = tx_send_q;
    tx_data_d = tx_data_q;
    gap_d     = gap_q;
    case (state_q)
      S_IDLE: begin
        if (!empty && !flush && !busy_q) begin
          tx_data_d = head_data;
          tx_send_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (busy_q) begin
          tx_send_d = 1'b0;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!busy_q) begin
          if (GAP_CYCLES > 0) begin
            gap_d   = GapW'(1);
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GapW'(GAP_CYCLES)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A rejected push and a clear on the same edge leave the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (wr_en && !flush && full && !pop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      tx_send_q  <= 1'b0;
      tx_data_q  <= '0;
      gap_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= tx_busy;
      tx_send_q  <= tx_send_d;
      tx_data_q  <= tx_data_d;
      gap_q      <= gap_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_send  = tx_send_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

endmodule
